logic_pipe_unit: RTL and testbench

- Parametrised successor to the fixed 16-bit bitwise OR array: a WIDTH-bit bitwise logic unit with selectable operation (AND/OR/XOR/NOR).
- Result is carried through a STAGES-deep register pipeline with valid/ready flow control and bubble collapsing, matching the multi-phase latency of the adiabatic datapath.
- Sits between the ALU operand latches and the result mux.

---
 rtl/logic_pipe_unit.sv | 91 +++++++++
 tb/tb_logic_pipe_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_pipe_unit.sv
// Parametrised bitwise logic unit (AND/OR/XOR/NOR) feeding a STAGES-deep valid/ready pipeline
// with bubble collapsing. Optional per-bit pass-through mask enabled by defining LOGIC_PIPE_MASK_EN.
module logic_pipe_unit #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clkpos,
  input  logic             reset,
  input  logic             vdd,
  input  logic             vss,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
`ifdef LOGIC_PIPE_MASK_EN
  input  logic [WIDTH-1:0] mask,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_zero
);

  logic [WIDTH-1:0] w_opResult;
  logic [WIDTH-1:0] w_result;
  logic             w_zero;
  logic [STAGES-1:0] w_adv;
  logic              w_unused_supply;

  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] r_zero;
  logic [WIDTH-1:0]  r_data [STAGES];

  assign w_unused_supply = vdd ^ vss;

  always_comb begin
    w_opResult = '0;
    case (op)
      2'b00:   w_opResult = a & b;
      2'b01:   w_opResult = a | b;
      2'b10:   w_opResult = a ^ b;
      default: w_opResult = ~(a | b);
    endcase
  end

`ifdef LOGIC_PIPE_MASK_EN
  // Unmasked bits pass operand A through untouched.
  assign w_result = (w_opResult & mask) | (a & ~mask);
`else
  assign w_result = w_opResult;
`endif

  assign w_zero = (w_result == '0);

  // A stage may load when it is empty or everything downstream of it can move;
  // this is the unrolled form of adv[i] = !valid[i] | adv[i+1].
  for (genvar g = 0; g < STAGES; g++) begin : g_adv
    assign w_adv[g] = out_ready | ~(&r_valid[STAGES-1:g]);
  end

  assign in_ready = w_adv[0] & ~reset;

  always_ff @(posedge clkpos) begin
    if (reset) begin
      r_valid <= '0;
      r_zero  <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      if (w_adv[0]) begin
        r_valid[0] <= in_valid;
        r_data[0]  <= w_result;
        r_zero[0]  <= w_zero;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (w_adv[i]) begin
          r_valid[i] <= r_valid[i-1];
          r_data[i]  <= r_data[i-1];
          r_zero[i]  <= r_zero[i-1];
        end
      end
    end
  end

  assign out_valid = r_valid[STAGES-1];
  assign out       = r_data[STAGES-1];
  assign out_zero  = r_zero[STAGES-1] & r_valid[STAGES-1];

endmodule

// File: tb/tb_logic_pipe_unit.sv
// Directed self-checking bench for logic_pipe_unit (WIDTH=16, STAGES=2).
// Define LOGIC_PIPE_MASK_EN for both files to exercise the mask port.
module tb_logic_pipe_unit;

   localparam int WIDTH  = 16;
   localparam int STAGES = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic             vdd;
   logic             vss;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [1:0]       op;
`ifdef LOGIC_PIPE_MASK_EN
   logic [WIDTH-1:0] mask;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic             out_zero;

   int totalChecks = 0;
   int passChecks  = 0;
   int outCount    = 0;
   logic [WIDTH-1:0] expQ[$];
   logic [WIDTH-1:0] curExp;

   logic [WIDTH-1:0] vecA   [10];
   logic [WIDTH-1:0] vecB   [10];
   logic [1:0]       vecOp  [10];
   logic [WIDTH-1:0] vecExp [10];

   always #5 clk = ~clk;

   logic_pipe_unit #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clkpos    (clk),
      .reset     (reset),
      .vdd       (vdd),
      .vss       (vss),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
`ifdef LOGIC_PIPE_MASK_EN
      .mask      (mask),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .out_zero  (out_zero)
   );

   // Every comparison funnels through here so counts and reporting stay consistent.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      totalChecks++;
      if (actual === expected) passChecks++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
   endtask

   task automatic applyStimulus(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                                input logic [1:0] top, input logic [WIDTH-1:0] texp);
      a        = ta;
      b        = tb;
      op       = top;
      curExp   = texp;
      in_valid = 1'b1;
   endtask

   task automatic applyVector(input int idx);
      applyStimulus(vecA[idx], vecB[idx], vecOp[idx], vecExp[idx]);
   endtask

   // One clock: scoreboard any output transfer and record any acceptance, then advance
   // past the edge; inputs are always changed 1ns after the edge.
   task automatic tick(output bit accepted);
      logic [WIDTH-1:0] e;
      #1;
      accepted = in_valid && in_ready;
      if (out_valid && out_ready) begin
         outCount++;
         checkOutput("q_nonempty", {31'b0, expQ.size() != 0}, 32'd1);
         if (expQ.size() != 0) begin
            e = expQ.pop_front();
            checkOutput("out_data", {16'b0, out}, {16'b0, e});
            checkOutput("out_zero", {31'b0, out_zero}, {31'b0, e == '0});
         end
      end
      if (accepted) expQ.push_back(curExp);
      @(posedge clk);
      #1;
   endtask

   task automatic drainPipe(input string tag);
      bit acc;
      int c;
      c = 0;
      in_valid = 1'b0;
      while (expQ.size() != 0 && c < 50) begin
         tick(acc);
         c++;
      end
      checkOutput(tag, expQ.size(), 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit   acc;
      int   n;
      int   idx;
      int   startCount;
      int   accCount;
      logic [9:0] obs;
      logic [9:0] expObs;
      logic [5:0] pat;

      vecA[0] = 16'hF0F0; vecB[0] = 16'hFF00; vecOp[0] = 2'b00; vecExp[0] = 16'hF000;
      vecA[1] = 16'hF0F0; vecB[1] = 16'hFF00; vecOp[1] = 2'b01; vecExp[1] = 16'hFFF0;
      vecA[2] = 16'hF0F0; vecB[2] = 16'hFF00; vecOp[2] = 2'b10; vecExp[2] = 16'h0FF0;
      vecA[3] = 16'hF0F0; vecB[3] = 16'hFF00; vecOp[3] = 2'b11; vecExp[3] = 16'h000F;
      vecA[4] = 16'h0000; vecB[4] = 16'h0000; vecOp[4] = 2'b00; vecExp[4] = 16'h0000;
      vecA[5] = 16'h00F0; vecB[5] = 16'h0F0F; vecOp[5] = 2'b01; vecExp[5] = 16'h0FFF;
      vecA[6] = 16'h1234; vecB[6] = 16'h5678; vecOp[6] = 2'b10; vecExp[6] = 16'h444C;
      vecA[7] = 16'hAAAA; vecB[7] = 16'h5555; vecOp[7] = 2'b00; vecExp[7] = 16'h0000;
      vecA[8] = 16'hAAAA; vecB[8] = 16'h5555; vecOp[8] = 2'b01; vecExp[8] = 16'hFFFF;
      vecA[9] = 16'h8001; vecB[9] = 16'h0100; vecOp[9] = 2'b11; vecExp[9] = 16'h7EFE;

      vdd = 1'b1;
      vss = 1'b0;
`ifdef LOGIC_PIPE_MASK_EN
      mask = '1;
`endif
      reset     = 1'b1;
      out_ready = 1'b1;
      applyVector(5);

      // Reset: nothing accepted, outputs cleared
      #2;
      checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd0);
      tick(acc);
      checkOutput("rst_accept", {31'b0, acc}, 32'd0);
      tick(acc);
      checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("rst_out", {16'b0, out}, 32'd0);
      checkOutput("rst_out_zero", {31'b0, out_zero}, 32'd0);
      reset    = 1'b0;
      in_valid = 1'b0;
      expQ.delete();

      // Basic OR with latency measurement
      applyVector(5);
      tick(acc);
      checkOutput("basic_accept", {31'b0, acc}, 32'd1);
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 20) begin
         tick(acc);
         n++;
      end
      checkOutput("basic_latency", n, STAGES);
      checkOutput("basic_out", {16'b0, out}, 32'h0FFF);
      drainPipe("basic_drain");

      // All four operations plus an all-zero result, back to back
      for (int i = 0; i < 5; i++) begin
         applyVector(i);
         tick(acc);
         checkOutput("ops_accept", {31'b0, acc}, 32'd1);
      end
      drainPipe("ops_drain");

      // Backpressure: only STAGES beats fit, output holds the first result
      out_ready = 1'b0;
      idx = 0;
      for (int c = 0; c < 4; c++) begin
         applyVector(idx);
         tick(acc);
         if (acc) idx++;
      end
      checkOutput("bp_accepted", idx, 2);
      checkOutput("bp_in_ready", {31'b0, in_ready}, 32'd0);
      checkOutput("bp_out_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("bp_hold_out", {16'b0, out}, {16'b0, vecExp[0]});
      in_valid = 1'b0;
      tick(acc);
      tick(acc);
      checkOutput("bp_hold_out2", {16'b0, out}, {16'b0, vecExp[0]});
      checkOutput("bp_hold_zero", {31'b0, out_zero}, 32'd0);
      out_ready  = 1'b1;
      startCount = outCount;
      n = 0;
      while ((outCount - startCount) < 4 && n < 20) begin
         if (idx < 4) applyVector(idx);
         else in_valid = 1'b0;
         tick(acc);
         if (acc) idx++;
         n++;
      end
      checkOutput("bp_drain_cycles", n, 4);
      drainPipe("bp_drain");

      // Full throughput with one input gap; the gap must reappear STAGES cycles later
      pat = 6'b110111;
      idx = 5;
      accCount = 0;
      for (int c = 0; c < 10; c++) begin
         if (c < 6 && pat[c]) applyVector(idx);
         else in_valid = 1'b0;
         tick(acc);
         if (acc) begin
            idx++;
            accCount++;
         end
         obs[c] = out_valid;
      end
      checkOutput("thr_accepts", accCount, 5);
      for (int c = 0; c < 10; c++) begin
         expObs[c] = (c + 1 - STAGES >= 0 && c + 1 - STAGES < 6) ? pat[c + 1 - STAGES] : 1'b0;
      end
      checkOutput("thr_pattern", {22'b0, obs}, {22'b0, expObs});
      drainPipe("thr_drain");

      // Reset with two beats in flight: discarded, then normal latency again
      out_ready = 1'b0;
      applyVector(6);
      tick(acc);
      applyVector(7);
      tick(acc);
      checkOutput("mid_full", {31'b0, out_valid}, 32'd1);
      reset = 1'b1;
      applyVector(8);
      #2;
      checkOutput("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
      tick(acc);
      checkOutput("mid_rst_accept", {31'b0, acc}, 32'd0);
      checkOutput("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("mid_rst_out", {16'b0, out}, 32'd0);
      checkOutput("mid_rst_zero", {31'b0, out_zero}, 32'd0);
      reset     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      expQ.delete();
      startCount = outCount;
      for (int c = 0; c < 5; c++) tick(acc);
      checkOutput("mid_no_stale", outCount - startCount, 0);
      applyVector(9);
      tick(acc);
      checkOutput("mid_accept", {31'b0, acc}, 32'd1);
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 20) begin
         tick(acc);
         n++;
      end
      checkOutput("mid_latency", n, STAGES);
      drainPipe("mid_drain");

`ifdef LOGIC_PIPE_MASK_EN
      // Masked XOR: upper byte passes A through
      mask = 16'h00FF;
      applyStimulus(16'h1234, 16'hFFFF, 2'b10, 16'h12CB);
      tick(acc);
      checkOutput("mask_accept", {31'b0, acc}, 32'd1);
      mask = 16'hFFFF;
      drainPipe("mask_drain");
`endif

      $display("%0d/%0d checks passed", passChecks, totalChecks);
      $finish;
   end

endmodule
